ex_mem_stage: RTL and testbench

Pipeline register and load/store control between the execute stage and the byte-addressed data memory. It captures the ALU result, store data, destination register and memory-op code at the end of EX. It drives the data memory's address, write data and 2-bit read/write size codes during MEM. It guarantees that each store is written exactly once even when the pipeline stalls, and it flags misaligned or out-of-range accesses.

---
 rtl/ex_mem_stage.sv | 127 ++++++++++++
 tb/tb_ex_mem_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with load/store size decode, single-issue store control and fault detection.
// Define EX_MEM_ALIGN_CHECK_EN to also treat misaligned word/half accesses as faults.
module ex_mem_stage #(
   parameter int unsigned MEM_BYTES = 40,
   parameter int unsigned FCNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              ex_valid,
   input  logic [31:0]       ex_alu_result,
   input  logic [31:0]       ex_store_data,
   input  logic [4:0]        ex_rd,
   input  logic              ex_regwrite,
   input  logic              ex_memtoreg,
   input  logic [2:0]        ex_mem_op,
   output logic [31:0]       address,
   output logic [31:0]       writedata,
   output logic [1:0]        memread,
   output logic [1:0]        memwrite,
   output logic              m_valid,
   output logic [4:0]        m_rd,
   output logic              m_regwrite,
   output logic              m_memtoreg,
   output logic [31:0]       m_alu_result,
   output logic              fault,
   output logic [FCNT_W-1:0] fault_count
);

   logic              valid_q, valid_d;
   logic [31:0]       alu_q, alu_d;
   logic [31:0]       sdata_q, sdata_d;
   logic [4:0]        rd_q, rd_d;
   logic              regwrite_q, regwrite_d;
   logic              memtoreg_q, memtoreg_d;
   logic [2:0]        op_q, op_d;
   logic              issued_q, issued_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              access_ok;

   // op[1:0] == 00 covers both "none" encodings (000 and 100).
   function automatic logic is_fault(input logic valid, input logic [2:0] op,
                                     input logic [31:0] addr);
      logic is_mem;
      logic oor;
      logic mis;
      is_mem = (op[1:0] != 2'b00);
      oor    = (({1'b0, addr} + 33'd3) >= 33'(MEM_BYTES));
      mis    = 1'b0;
`ifdef EX_MEM_ALIGN_CHECK_EN
      mis    = ((op[1:0] == 2'b01) && (addr[1:0] != 2'b00)) ||
               ((op[1:0] == 2'b11) && addr[0]);
`endif
      return valid && is_mem && (oor || mis);
   endfunction

   always_comb begin
      valid_d    = valid_q;
      alu_d      = alu_q;
      sdata_d    = sdata_q;
      rd_d       = rd_q;
      regwrite_d = regwrite_q;
      memtoreg_d = memtoreg_q;
      op_d       = op_q;
      issued_d   = issued_q;
      fcnt_d     = fcnt_q;
      if (flush) begin
         valid_d    = 1'b0;
         regwrite_d = 1'b0;
         op_d       = 3'b000;
         issued_d   = 1'b0;
      end else if (stall) begin
         // The held entry has already had its one write cycle.
         issued_d = 1'b1;
      end else begin
         valid_d    = ex_valid;
         alu_d      = ex_alu_result;
         sdata_d    = ex_store_data;
         rd_d       = ex_rd;
         regwrite_d = ex_valid & ex_regwrite;
         memtoreg_d = ex_memtoreg;
         op_d       = ex_valid ? ex_mem_op : 3'b000;
         issued_d   = 1'b0;
         if (is_fault(ex_valid, ex_mem_op, ex_alu_result) && !(&fcnt_q))
            fcnt_d = fcnt_q + FCNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         alu_q      <= '0;
         sdata_q    <= '0;
         rd_q       <= '0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         op_q       <= 3'b000;
         issued_q   <= 1'b0;
         fcnt_q     <= '0;
      end else begin
         valid_q    <= valid_d;
         alu_q      <= alu_d;
         sdata_q    <= sdata_d;
         rd_q       <= rd_d;
         regwrite_q <= regwrite_d;
         memtoreg_q <= memtoreg_d;
         op_q       <= op_d;
         issued_q   <= issued_d;
         fcnt_q     <= fcnt_d;
      end
   end

   assign fault        = is_fault(valid_q, op_q, alu_q);
   assign access_ok    = valid_q & ~fault;
   assign memread      = (access_ok && !op_q[2]) ? op_q[1:0] : 2'b00;
   assign memwrite     = (access_ok && op_q[2] && !issued_q) ? op_q[1:0] : 2'b00;
   assign address      = alu_q;
   assign writedata    = sdata_q;
   assign m_valid      = valid_q;
   assign m_rd         = rd_q;
   assign m_regwrite   = regwrite_q & ~fault;
   assign m_memtoreg   = memtoreg_q;
   assign m_alu_result = alu_q;
   assign fault_count  = fcnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed and randomized bench for ex_mem_stage against a behavioural entry/hold-count model.
// Honours EX_MEM_ALIGN_CHECK_EN in the model the same way the design does.
module tb_ex_mem_stage;
   localparam int MEM_BYTES = 40;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, ex_valid = 1'b0;
   logic [31:0] ex_alu_result = '0, ex_store_data = '0;
   logic [4:0]  ex_rd = '0;
   logic        ex_regwrite = 1'b0, ex_memtoreg = 1'b0;
   logic [2:0]  ex_mem_op = '0;
   logic [31:0] address, writedata, m_alu_result;
   logic [1:0]  memread, memwrite;
   logic        m_valid, m_regwrite, m_memtoreg, fault;
   logic [4:0]  m_rd;
   logic [7:0]  fault_count;

   int checks = 0;
   int failures = 0;

   // model of the entry sitting in MEM
   bit        e_valid;
   bit [31:0] e_alu, e_sd;
   bit [4:0]  e_rd;
   bit        e_rw, e_mtr;
   bit [2:0]  e_op;
   int        e_held;
   int        e_fc;

   ex_mem_stage #(.MEM_BYTES(MEM_BYTES), .FCNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_mem_op(ex_mem_op),
      .address(address), .writedata(writedata), .memread(memread), .memwrite(memwrite),
      .m_valid(m_valid), .m_rd(m_rd), .m_regwrite(m_regwrite), .m_memtoreg(m_memtoreg),
      .m_alu_result(m_alu_result), .fault(fault), .fault_count(fault_count)
   );

   always #5 clk = ~clk;

   function automatic bit m_is_load(bit [2:0] op);
      return op inside {3'd1, 3'd2, 3'd3};
   endfunction

   function automatic bit m_is_store(bit [2:0] op);
      return op inside {3'd5, 3'd6, 3'd7};
   endfunction

   function automatic bit [1:0] m_size(bit [2:0] op);
      case (op)
         3'd1, 3'd5: return 2'b01;
         3'd2, 3'd6: return 2'b10;
         3'd3, 3'd7: return 2'b11;
         default:    return 2'b00;
      endcase
   endfunction

   function automatic bit m_fault(bit v, bit [2:0] op, bit [31:0] a);
      bit mis;
      longint ea;
      ea  = longint'(a);
      mis = 1'b0;
`ifdef EX_MEM_ALIGN_CHECK_EN
      mis = ((op == 3'd1 || op == 3'd5) && (a % 4 != 0)) ||
            ((op == 3'd3 || op == 3'd7) && (a % 2 != 0));
`endif
      return v && (m_is_load(op) || m_is_store(op)) && ((ea + 3 >= MEM_BYTES) || mis);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      e_valid = 0; e_alu = 0; e_sd = 0; e_rd = 0; e_rw = 0; e_mtr = 0; e_op = 0;
      e_held = 0; e_fc = 0;
   endtask

   task automatic compare_all();
      bit f;
      f = m_fault(e_valid, e_op, e_alu);
      check("m_valid", 64'(m_valid), 64'(e_valid));
      check("fault", 64'(fault), 64'(f));
      check("fault_count", 64'(fault_count), 64'(e_fc));
      check("memread", 64'(memread),
            64'((e_valid && !f && m_is_load(e_op)) ? m_size(e_op) : 2'b00));
      check("memwrite", 64'(memwrite),
            64'((e_valid && !f && m_is_store(e_op) && e_held == 0) ? m_size(e_op) : 2'b00));
      check("m_regwrite", 64'(m_regwrite), 64'(e_valid && e_rw && !f));
      if (e_valid) begin
         check("address", 64'(address), 64'(e_alu));
         check("writedata", 64'(writedata), 64'(e_sd));
         check("m_alu_result", 64'(m_alu_result), 64'(e_alu));
         check("m_rd", 64'(m_rd), 64'(e_rd));
         check("m_memtoreg", 64'(m_memtoreg), 64'(e_mtr));
      end
   endtask

   task automatic step(input bit st, input bit fl, input bit v, input bit [2:0] op,
                       input bit [31:0] a, input bit [31:0] sd, input bit [4:0] rd,
                       input bit rw, input bit mtr);
      stall = st; flush = fl; ex_valid = v; ex_mem_op = op; ex_alu_result = a;
      ex_store_data = sd; ex_rd = rd; ex_regwrite = rw; ex_memtoreg = mtr;
      @(posedge clk);
      if (fl) begin
         e_valid = 0; e_rw = 0; e_op = 0; e_held = 0;
      end else if (st) begin
         e_held++;
      end else begin
         if (m_fault(v, op, a) && e_fc < 255) e_fc++;
         e_valid = v; e_alu = a; e_sd = sd; e_rd = rd; e_mtr = mtr;
         e_rw = v && rw;
         e_op = v ? op : 3'd0;
         e_held = 0;
      end
      #1;
      compare_all();
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      #12;
      compare_all();
      check("rst_memwrite", 64'(memwrite), 64'(2'b00));
      @(negedge clk);
      rst_n = 1'b1;

      // sw 0xDEADBEEF -> 8: exactly one write cycle
      step(0, 0, 1, 3'd5, 32'd8, 32'hDEADBEEF, 5'd0, 0, 0);
      check("sw_we", 64'(memwrite), 64'(2'b01));
      check("sw_addr", 64'(address), 64'(32'd8));
      check("sw_wdata", 64'(writedata), 64'(32'hDEADBEEF));
      step(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 0);
      check("sw_one_cycle", 64'(memwrite), 64'(2'b00));

      // sh -> 4 held for three stalled cycles
      step(0, 0, 1, 3'd7, 32'd4, 32'h0000BEEF, 5'd0, 0, 0);
      check("sh_we_first", 64'(memwrite), 64'(2'b11));
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 1, 3'd5, 32'd0, 32'h1234, 5'd3, 1, 0);
         check("sh_we_held", 64'(memwrite), 64'(2'b00));
      end

      // lb from 12 with two stalled cycles
      step(0, 0, 1, 3'd2, 32'd12, 32'd0, 5'd7, 1, 1);
      for (int i = 0; i < 3; i++) begin
         check("lb_re", 64'(memread), 64'(2'b10));
         check("lb_rw", 64'(m_regwrite), 64'(1'b1));
         if (i < 2) step(1, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0, 0);
      end

      // lw 38 is out of range
      step(0, 0, 1, 3'd1, 32'd38, 32'd0, 5'd9, 1, 1);
      check("oor_fault", 64'(fault), 64'(1'b1));
      check("oor_re", 64'(memread), 64'(2'b00));
      check("oor_rw", 64'(m_regwrite), 64'(1'b0));
      check("oor_cnt", 64'(fault_count), 64'(8'd1));
      // top of range: 36+3 = 39 is in range
      step(0, 0, 1, 3'd1, 32'd36, 32'd0, 5'd9, 1, 1);
      check("edge_ok", 64'(fault), 64'(1'b0));
      step(0, 0, 1, 3'd6, 32'd37, 32'd5, 5'd0, 0, 0);
      check("edge_bad", 64'(fault), 64'(1'b1));

      // lw from 2
      step(0, 0, 1, 3'd1, 32'd2, 32'd0, 5'd4, 1, 1);
`ifdef EX_MEM_ALIGN_CHECK_EN
      check("mis_fault", 64'(fault), 64'(1'b1));
      check("mis_cnt", 64'(fault_count), 64'(8'd3));
`else
      check("mis_re", 64'(memread), 64'(2'b01));
      check("mis_nofault", 64'(fault), 64'(1'b0));
`endif

      // stall+flush together while a sw sits in MEM
      step(0, 0, 1, 3'd5, 32'd16, 32'hCAFEF00D, 5'd0, 0, 0);
      step(1, 1, 1, 3'd5, 32'd20, 32'h1, 5'd0, 0, 0);
      check("sf_valid", 64'(m_valid), 64'(1'b0));
      check("sf_we", 64'(memwrite), 64'(2'b00));

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit [31:0] a;
         a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 47));
         step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 5) != 0,
              3'($urandom_range(0, 7)), a, $urandom, 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // async reset in the middle of a store cycle
      step(0, 0, 1, 3'd5, 32'd24, 32'hA5A5A5A5, 5'd0, 0, 0);
      check("pre_rst_we", 64'(memwrite), 64'(2'b01));
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_we", 64'(memwrite), 64'(2'b00));
      check("rst_valid", 64'(m_valid), 64'(1'b0));
      check("rst_cnt", 64'(fault_count), 64'(8'd0));
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 1, 3'd5, 32'd24, 32'hA5A5A5A5, 5'd0, 0, 0);
      check("post_rst_we", 64'(memwrite), 64'(2'b00));

      // counter saturation
      for (int i = 0; i < 256; i++) step(0, 0, 1, 3'd1, 32'd38, 32'd0, 5'd1, 1, 0);
      check("sat_cnt", 64'(fault_count), 64'(8'd255));
      step(0, 0, 1, 3'd5, 32'd100, 32'd0, 5'd0, 0, 0);
      check("sat_hold", 64'(fault_count), 64'(8'd255));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
